// File: rtl/riscv_mc_core.sv
// Multicycle RV32I core: IF/ID/EX/MEM/WB over one ALU.
// Instruction and data memories are reached through req/ack ports.
module riscv_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IADDR_W  = 10,
  parameter int          DADDR_W  = 14,
  parameter logic [31:0] EOF_WORD = 32'hFFFF_FFFF,
  parameter int          CNT_W    = 32
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack,
  output logic               done,
  output logic               trap,
  output logic [CNT_W-1:0]   clock_count,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  state_t      state, nxt;
  logic [31:0] pc, ir, alu_out, mdr, a, b;
  logic [31:0] rf [32];
  logic [31:0] imm, op2, arith, alu_y, pc_nxt;
  logic        ireq, dreq, retire, take;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2, sh;
  logic [2:0] f3;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_lui, is_aui, is_jal, is_jr, legal;
  assign is_r   = opc == OP_R;
  assign is_i   = opc == OP_I;
  assign is_ld  = opc == OP_LD;
  assign is_st  = opc == OP_ST;
  assign is_br  = opc == OP_BR;
  assign is_lui = opc == OP_LUI;
  assign is_aui = opc == OP_AUI;
  assign is_jal = opc == OP_JAL;
  assign is_jr  = opc == OP_JR;
  assign legal  = |{is_r, is_i, is_ld, is_st, is_br,
                    is_lui, is_aui, is_jal, is_jr};

  // immediate extraction by instruction format
  always_comb begin
    imm = {{20{ir[31]}}, ir[31:20]};
    unique case (1'b1)
      is_st:
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      is_br:
        imm = {{19{ir[31]}}, ir[31], ir[7],
               ir[30:25], ir[11:8], 1'b0};
      is_lui | is_aui:
        imm = {ir[31:12], 12'b0};
      is_jal:
        imm = {{11{ir[31]}}, ir[31], ir[19:12],
               ir[20], ir[30:21], 1'b0};
      default:
        imm = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  assign op2 = is_r ? b : imm;
  assign sh  = op2[4:0];

  // integer ALU for register and immediate forms
  always_comb begin
    arith = '0;
    case (f3)
      3'b000: arith = (is_r && ir[30]) ? a - op2 : a + op2;
      3'b001: arith = a << sh;
      3'b010: arith = {31'b0, $signed(a) < $signed(op2)};
      3'b011: arith = {31'b0, a < op2};
      3'b100: arith = a ^ op2;
      3'b101: arith = ir[30] ? 32'($signed(a) >>> sh) : a >> sh;
      3'b110: arith = a | op2;
      default: arith = a & op2;
    endcase
  end

  // EX result and next PC selection
  always_comb begin
    alu_y = a + imm;
    unique case (1'b1)
      is_r | is_i:    alu_y = arith;
      is_lui:         alu_y = imm;
      is_aui:         alu_y = pc + imm;
      is_jal | is_jr: alu_y = pc + 32'd4;
      default:        alu_y = a + imm;
    endcase
    case (f3)
      3'b000:  take = a == b;
      3'b001:  take = a != b;
      3'b100:  take = $signed(a) < $signed(b);
      3'b101:  take = $signed(a) >= $signed(b);
      3'b110:  take = a < b;
      3'b111:  take = a >= b;
      default: take = 1'b0;
    endcase
    pc_nxt = pc + 32'd4;
    if ((is_br && take) || is_jal) pc_nxt = pc + imm;
    if (is_jr) pc_nxt = (a + imm) & ~32'd1;
  end

  // next-state, request and retire decode
  always_comb begin
    nxt    = state;
    ireq   = 1'b0;
    dreq   = 1'b0;
    retire = 1'b0;
    case (state)
      S_IF: begin
        ireq = 1'b1;
        if (imem_ack) nxt = S_ID;
      end
      S_ID:
        nxt = (ir == EOF_WORD || !legal) ? S_HALT : S_EX;
      S_EX: begin
        if (is_br) begin
          nxt    = S_IF;
          retire = 1'b1;
        end else if (is_ld || is_st) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        dreq = 1'b1;
        if (dmem_ack) begin
          nxt    = is_st ? S_IF : S_WB;
          retire = is_st;
        end
      end
      S_WB: begin
        nxt    = S_IF;
        retire = 1'b1;
      end
      default: nxt = S_HALT;
    endcase
  end

  assign imem_req   = ireq & ~rst;
  assign dmem_req   = dreq & ~rst;
  assign dmem_we    = dmem_req & is_st;
  assign imem_addr  = pc[IADDR_W+1:2];
  assign dmem_addr  = alu_out[DADDR_W+1:2];
  assign dmem_wdata = b;

  // datapath registers, status flags and counters
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state       <= S_IF;
      pc          <= RESET_PC;
      ir          <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      a           <= '0;
      b           <= '0;
      done        <= 1'b0;
      trap        <= 1'b0;
      clock_count <= '0;
      instr_cnt   <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IF:  if (imem_ack) ir <= imem_rdata;
        S_ID: begin
          a <= (rs1 == 5'd0) ? 32'd0 : rf[rs1];
          b <= (rs2 == 5'd0) ? 32'd0 : rf[rs2];
        end
        S_EX: begin
          alu_out <= alu_y;
          pc      <= pc_nxt;
        end
        S_MEM: if (dmem_ack && !is_st) mdr <= dmem_rdata;
        default: ;
      endcase
      if (nxt == S_HALT) done <= 1'b1;
      if (state == S_ID && ir != EOF_WORD && !legal)
        trap <= 1'b1;
      if (state != S_HALT && nxt != S_HALT &&
          clock_count != {CNT_W{1'b1}})
        clock_count <= clock_count + CNT_W'(1);
      if (retire && instr_cnt != {CNT_W{1'b1}})
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // register file write-back; x0 is never written
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB && rd != 5'd0) begin
      rf[rd] <= is_ld ? mdr : alu_out;
    end
  end

endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed bench for riscv_mc_core with req/ack memory models.
// Results are dumped to data memory with SW and compared there.
module tb_riscv_mc_core;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [9:0]  imem_addr;
  logic [13:0] dmem_addr;
  logic [31:0] imem_rdata, dmem_rdata, dmem_wdata;
  logic        done, trap;
  logic [31:0] clock_count, instr_cnt;

  logic [31:0] imem [1024];
  logic [31:0] dmem [16384];
  int          idly = 0, ddly = 0;
  int          icnt, dcnt, dlen, dmin, dmax, viol;
  logic        force_iack = 1'b0;
  int          nerr = 0, nchk = 0;

  riscv_mc_core dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .done       (done),
    .trap       (trap),
    .clock_count(clock_count),
    .instr_cnt  (instr_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign imem_ack   = (imem_req && icnt >= idly) || force_iack;
  assign imem_rdata = force_iack ? 32'h0000_007F : imem[imem_addr];
  assign dmem_ack   = dmem_req && dcnt >= ddly;
  assign dmem_rdata = dmem[dmem_addr];

  // memory wait-state counters and request-length tracking
  always @(posedge CLOCK_50) begin
    if (rst) begin
      icnt <= 0; dcnt <= 0; dlen <= 0;
      dmin <= 999; dmax <= 0; viol <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      if (imem_req && dmem_req) viol <= viol + 1;
      if (dmem_req) begin
        if (dmem_ack) begin
          dlen <= 0;
          if (dlen + 1 < dmin) dmin <= dlen + 1;
          if (dlen + 1 > dmax) dmax <= dlen + 1;
          if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        end else begin
          dlen <= dlen + 1;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1,
                                        int f3, int rd,
                                        logic [6:0] op);
    logic [31:0] t;
    t = imm;
    return {t[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2,
                                        int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd),
            7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2,
                                        int rs1);
    logic [31:0] t;
    t = imm;
    return {t[11:5], 5'(rs2), 5'(rs1), 3'b010, t[4:0],
            7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2,
                                        int rs1, int f3);
    logic [31:0] t;
    t = imm;
    return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            t[4:1], t[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd,
                                        logic [6:0] op);
    logic [31:0] t;
    t = imm20;
    return {t[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] t;
    t = imm;
    return {t[20], t[10:1], t[11], t[19:12], 5'(rd),
            7'b1101111};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction

  task automatic clear_mem;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16384; i++) dmem[i] = 32'h0;
  endtask

  task automatic load_prog_a;
    clear_mem();
    imem[0] = addi(1, 0, 5);
    imem[1] = addi(2, 0, -3);
    imem[2] = enc_r(0, 2, 1, 0, 3);
    imem[3] = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    rst = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge CLOCK_50);
      n++;
    end
    @(negedge CLOCK_50);
    check(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    int quiet;
    logic [31:0] cc_hold;

    // reset state
    repeat (2) @(negedge CLOCK_50);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_trap", {31'b0, trap}, 32'd0);
    check("rst_clock_count", clock_count, 32'd0);
    check("rst_instr_cnt", instr_cnt, 32'd0);

    // ADDI/ADDI/ADD/EOF with zero-wait memories
    load_prog_a();
    idly = 0; ddly = 0;
    do_reset();
    run_to_done("a_done", 200);
    check("a_trap", {31'b0, trap}, 32'd0);
    check("a_instr_cnt", instr_cnt, 32'd3);
    check("a_clock_count", clock_count, 32'd13);

    // mixed program, slow data memory
    clear_mem();
    dmem[2]  = 32'hDEAD_BEEF;
    imem[0]  = addi(1, 0, 5);
    imem[1]  = addi(2, 0, -3);
    imem[2]  = enc_r(0, 2, 1, 0, 3);
    imem[3]  = enc_s(64, 3, 0);
    imem[4]  = addi(0, 0, 7);
    imem[5]  = enc_s(68, 0, 0);
    imem[6]  = enc_u(32'h12345, 5, 7'b0110111);
    imem[7]  = addi(5, 5, 32'h678);
    imem[8]  = enc_j(8, 1);
    imem[9]  = addi(7, 0, 99);
    imem[10] = enc_s(72, 5, 0);
    imem[11] = enc_s(76, 1, 0);
    imem[12] = addi(8, 0, -1);
    imem[13] = addi(9, 0, 1);
    imem[14] = enc_b(8, 9, 8, 3'b100);
    imem[15] = addi(10, 0, 1);
    imem[16] = enc_b(8, 9, 8, 3'b110);
    imem[17] = addi(11, 0, 2);
    imem[18] = enc_s(80, 10, 0);
    imem[19] = enc_s(84, 11, 0);
    imem[20] = enc_s(88, 7, 0);
    imem[21] = enc_i(8, 0, 2, 4, 7'b0000011);
    imem[22] = enc_s(12, 4, 0);
    imem[23] = enc_r(32, 8, 9, 0, 12);
    imem[24] = enc_s(92, 12, 0);
    imem[25] = enc_u(1, 13, 7'b0010111);
    imem[26] = enc_s(96, 13, 0);
    imem[27] = 32'hFFFF_FFFF;
    idly = 1; ddly = 3;
    do_reset();
    run_to_done("b_done", 3000);
    check("b_trap", {31'b0, trap}, 32'd0);
    check("b_instr_cnt", instr_cnt, 32'd25);
    check("b_add_x3", dmem[16], 32'd2);
    check("b_x0_zero", dmem[17], 32'd0);
    check("b_lui_addi", dmem[18], 32'h1234_5678);
    check("b_jal_link", dmem[19], 32'h24);
    check("b_blt_taken", dmem[20], 32'd0);
    check("b_bltu_not_taken", dmem[21], 32'd2);
    check("b_jal_skip", dmem[22], 32'd0);
    check("b_lw_sw", dmem[3], 32'hDEAD_BEEF);
    check("b_sub", dmem[23], 32'd2);
    check("b_auipc", dmem[24], 32'h1064);
    check("b_dreq_min_len", dmin, 32'd4);
    check("b_dreq_max_len", dmax, 32'd4);
    check("b_req_overlap", viol, 32'd0);

    // illegal opcode halts with trap
    clear_mem();
    imem[0] = addi(1, 0, 1);
    imem[1] = 32'h0000_007F;
    idly = 0; ddly = 0;
    do_reset();
    run_to_done("c_done", 200);
    check("c_trap", {31'b0, trap}, 32'd1);
    check("c_instr_cnt", instr_cnt, 32'd1);
    check("c_clock_count", clock_count, 32'd5);
    cc_hold = clock_count;
    quiet = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (imem_req || dmem_req) quiet++;
    end
    check("c_no_req_after_halt", quiet, 32'd0);
    check("c_count_frozen", clock_count, cc_hold);
    check("c_done_sticky", {31'b0, done}, 32'd1);

    // reset while a fetch is pending; the late ack is ignored
    load_prog_a();
    idly = 5;
    do_reset();
    repeat (2) @(negedge CLOCK_50);
    check("ab_req_pending", {31'b0, imem_req}, 32'd1);
    rst = 1'b1;
    force_iack = 1'b1;
    #1;
    check("ab_req_cleared", {31'b0, imem_req}, 32'd0);
    check("ab_cc_cleared", clock_count, 32'd0);
    check("ab_done_cleared", {31'b0, done}, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    force_iack = 1'b0;
    idly = 0;
    rst = 1'b0;
    #1;
    check("ab_restart_addr", {22'b0, imem_addr}, 32'd0);
    check("ab_restart_req", {31'b0, imem_req}, 32'd1);
    run_to_done("ab_done", 200);
    check("ab_trap", {31'b0, trap}, 32'd0);
    check("ab_instr_cnt", instr_cnt, 32'd3);
    check("ab_clock_count", clock_count, 32'd13);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
